// File: rtl/transformation_pkg.sv
// Shared types and default widths for the transformation-stage sequencer and its dot-product multiplier.
package transformation_pkg;

   localparam int FEATURE_ROWS_D   = 6;
   localparam int WEIGHT_COLS_D    = 3;
   localparam int FEATURE_WIDTH_D  = 5;
   localparam int WEIGHT_WIDTH_D   = 5;
   localparam int VECTOR_LENGTH_D  = 96;
   localparam int DOT_PROD_WIDTH_D = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_W,
      FETCH_F,
      RUN,
      DRAIN,
      FINISH,
      COMPLETE
   } state_t;

   typedef logic [FEATURE_WIDTH_D*VECTOR_LENGTH_D-1:0] feature_vec_t;
   typedef logic [WEIGHT_WIDTH_D*VECTOR_LENGTH_D-1:0]  weight_vec_t;

endpackage

// File: rtl/transformation_sequencer_if.sv
// Memory, multiplier and result-memory signals seen by the transformation sequencer.
interface transformation_sequencer_if
   import transformation_pkg::*;
#(
   parameter int FEATURE_WIDTH         = FEATURE_WIDTH_D,
   parameter int WEIGHT_WIDTH          = WEIGHT_WIDTH_D,
   parameter int VECTOR_LENGTH         = VECTOR_LENGTH_D,
   parameter int DOT_PROD_WIDTH        = DOT_PROD_WIDTH_D,
   parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS_D),
   parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS_D)
) ();

   logic                                     start;
   logic [COUNTER_FEATURE_WIDTH-1:0]         read_feature_address;
   logic                                     read_feature_enable;
   logic [FEATURE_WIDTH*VECTOR_LENGTH-1:0]   feature_data;
   logic [COUNTER_WEIGHT_WIDTH-1:0]          read_weight_address;
   logic                                     read_weight_enable;
   logic [WEIGHT_WIDTH*VECTOR_LENGTH-1:0]    weight_data;
   logic [FEATURE_WIDTH*VECTOR_LENGTH-1:0]   FM_row;
   logic [WEIGHT_WIDTH*VECTOR_LENGTH-1:0]    WM_col;
   logic                                     MULTI_EN;
   logic                                     TRANS_DONE;
   logic                                     INCR_FEATURE;
   logic                                     done;
   logic [DOT_PROD_WIDTH-1:0]                product;
   logic                                     result_write_enable;
   logic [COUNTER_FEATURE_WIDTH-1:0]         result_row_address;
   logic [COUNTER_WEIGHT_WIDTH-1:0]          result_col_address;
   logic [DOT_PROD_WIDTH-1:0]                result_data;
   logic                                     busy;
   logic                                     complete;
   logic                                     result_overrun;

   modport master (
      input  start, feature_data, weight_data, INCR_FEATURE, done, product,
      output read_feature_address, read_feature_enable, read_weight_address, read_weight_enable,
             FM_row, WM_col, MULTI_EN, TRANS_DONE, result_write_enable, result_row_address,
             result_col_address, result_data, busy, complete, result_overrun
   );

   modport slave (
      output start, feature_data, weight_data, INCR_FEATURE, done, product,
      input  read_feature_address, read_feature_enable, read_weight_address, read_weight_enable,
             FM_row, WM_col, MULTI_EN, TRANS_DONE, result_write_enable, result_row_address,
             result_col_address, result_data, busy, complete, result_overrun
   );

endinterface

// File: rtl/transformation_sequencer_result_writer.sv
// Tracks issued-but-unfinished dot products and writes each product to the result memory in issue order.
module result_writer
   import transformation_pkg::*;
#(
   parameter int FEATURE_ROWS          = FEATURE_ROWS_D,
   parameter int WEIGHT_COLS           = WEIGHT_COLS_D,
   parameter int DOT_PROD_WIDTH        = DOT_PROD_WIDTH_D,
   parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
   parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              clear,
   input  logic                              incr,
   input  logic                              done,
   input  logic signed [DOT_PROD_WIDTH-1:0]  product,
   output logic                              write_enable,
   output logic [COUNTER_FEATURE_WIDTH-1:0]  row_address,
   output logic [COUNTER_WEIGHT_WIDTH-1:0]   col_address,
   output logic signed [DOT_PROD_WIDTH-1:0]  data,
   output logic [1:0]                        outstanding,
   output logic                              overrun
);

   localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
   localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_COL = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

   logic [COUNTER_FEATURE_WIDTH-1:0] res_row;
   logic [COUNTER_WEIGHT_WIDTH-1:0]  res_col;
   logic                             take;

   // A done that coincides with a new issue is always backed by that issue.
   assign take = done && (incr || (outstanding != 2'd0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outstanding  <= 2'd0;
         res_row      <= '0;
         res_col      <= '0;
         write_enable <= 1'b0;
         row_address  <= '0;
         col_address  <= '0;
         data         <= '0;
         overrun      <= 1'b0;
      end else if (clear) begin
         outstanding  <= 2'd0;
         res_row      <= '0;
         res_col      <= '0;
         write_enable <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         write_enable <= take;
         if (take) begin
            data        <= product;
            row_address <= res_row;
            col_address <= res_col;
            if (res_row == LAST_ROW) begin
               res_row <= '0;
               res_col <= (res_col == LAST_COL) ? '0 : res_col + 1'b1;
            end else begin
               res_row <= res_row + 1'b1;
            end
         end
         if (done && !take)
            overrun <= 1'b1;
         if (incr && !done && (outstanding != 2'd3))
            outstanding <= outstanding + 2'd1;
         else if (done && !incr && (outstanding != 2'd0))
            outstanding <= outstanding - 2'd1;
      end
   end

endmodule

// File: rtl/transformation_sequencer.sv
// Fetches weight columns and feature rows for the dot-product multiplier and sequences a full FM x WM pass.
module transformation_sequencer
   import transformation_pkg::*;
#(
   parameter int FEATURE_ROWS          = FEATURE_ROWS_D,
   parameter int WEIGHT_COLS           = WEIGHT_COLS_D,
   parameter int FEATURE_WIDTH         = FEATURE_WIDTH_D,
   parameter int WEIGHT_WIDTH          = WEIGHT_WIDTH_D,
   parameter int VECTOR_LENGTH         = VECTOR_LENGTH_D,
   parameter int DOT_PROD_WIDTH        = DOT_PROD_WIDTH_D,
   parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
   parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   transformation_sequencer_if.master  bus
);

   localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
   localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_COL = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

   state_t                                 state;
   logic                                   phase;
   logic [COUNTER_FEATURE_WIDTH-1:0]       issue_row;
   logic [COUNTER_WEIGHT_WIDTH-1:0]        issue_col;
   logic                                   pf_vld;
   logic [FEATURE_WIDTH*VECTOR_LENGTH-1:0] next_buf;
   logic [1:0]                             outstanding;
   logic                                   row_incr;
   logic                                   writer_clear;

   assign row_incr     = bus.INCR_FEATURE && (state == RUN);
   assign writer_clear = (state == IDLE) && bus.start;

   // Prefetched row lands here one cycle after its read strobe.
   always_ff @(posedge clk) begin
      if (pf_vld)
         next_buf <= bus.feature_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                    <= IDLE;
         phase                    <= 1'b0;
         issue_row                <= '0;
         issue_col                <= '0;
         pf_vld                   <= 1'b0;
         bus.read_feature_address <= '0;
         bus.read_feature_enable  <= 1'b0;
         bus.read_weight_address  <= '0;
         bus.read_weight_enable   <= 1'b0;
         bus.FM_row               <= '0;
         bus.WM_col               <= '0;
         bus.MULTI_EN             <= 1'b0;
         bus.TRANS_DONE           <= 1'b0;
         bus.busy                 <= 1'b0;
         bus.complete             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state                   <= FETCH_W;
                  phase                   <= 1'b0;
                  issue_row               <= '0;
                  issue_col               <= '0;
                  bus.read_weight_enable  <= 1'b1;
                  bus.read_weight_address <= '0;
                  bus.busy                <= 1'b1;
               end
            end
            FETCH_W: begin
               if (!phase) begin
                  bus.read_weight_enable <= 1'b0;
                  phase                  <= 1'b1;
               end else begin
                  bus.WM_col               <= bus.weight_data;
                  bus.read_feature_enable  <= 1'b1;
                  bus.read_feature_address <= issue_row;
                  phase                    <= 1'b0;
                  state                    <= FETCH_F;
               end
            end
            FETCH_F: begin
               if (!phase) begin
                  bus.read_feature_enable <= 1'b0;
                  phase                   <= 1'b1;
               end else begin
                  bus.FM_row   <= bus.feature_data;
                  bus.MULTI_EN <= 1'b1;
                  phase        <= 1'b0;
                  state        <= RUN;
                  if (issue_row != LAST_ROW) begin
                     bus.read_feature_enable  <= 1'b1;
                     bus.read_feature_address <= issue_row + 1'b1;
                  end
               end
            end
            RUN: begin
               bus.read_feature_enable <= 1'b0;
               pf_vld                  <= bus.read_feature_enable;
               if (bus.INCR_FEATURE) begin
                  if (issue_row != LAST_ROW) begin
                     // Bypass covers an advance in the same cycle the prefetch data arrives.
                     bus.FM_row <= pf_vld ? bus.feature_data : next_buf;
                     issue_row  <= issue_row + 1'b1;
                     if ((issue_row + 1'b1) != LAST_ROW) begin
                        bus.read_feature_enable  <= 1'b1;
                        bus.read_feature_address <= issue_row + 2'd2;
                     end
                  end else begin
                     bus.MULTI_EN <= 1'b0;
                     state        <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               pf_vld <= 1'b0;
               if (outstanding == 2'd0) begin
                  if (issue_col != LAST_COL) begin
                     issue_col               <= issue_col + 1'b1;
                     issue_row               <= '0;
                     bus.read_weight_enable  <= 1'b1;
                     bus.read_weight_address <= issue_col + 1'b1;
                     state                   <= FETCH_W;
                  end else begin
                     bus.TRANS_DONE <= 1'b1;
                     state          <= FINISH;
                  end
               end
            end
            FINISH: begin
               bus.TRANS_DONE <= 1'b0;
               bus.complete   <= 1'b1;
               bus.busy       <= 1'b0;
               state          <= COMPLETE;
            end
            COMPLETE: begin
               if (!bus.start) begin
                  bus.complete <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   result_writer #(
      .FEATURE_ROWS          (FEATURE_ROWS),
      .WEIGHT_COLS           (WEIGHT_COLS),
      .DOT_PROD_WIDTH        (DOT_PROD_WIDTH),
      .COUNTER_FEATURE_WIDTH (COUNTER_FEATURE_WIDTH),
      .COUNTER_WEIGHT_WIDTH  (COUNTER_WEIGHT_WIDTH)
   ) u_result_writer (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (writer_clear),
      .incr         (row_incr),
      .done         (bus.done),
      .product      (bus.product),
      .write_enable (bus.result_write_enable),
      .row_address  (bus.result_row_address),
      .col_address  (bus.result_col_address),
      .data         (bus.result_data),
      .outstanding  (outstanding),
      .overrun      (bus.result_overrun)
   );

endmodule

// File: tb/tb_transformation_sequencer.sv
// Directed bench for transformation_sequencer: memory and multiplier models plus scenario tasks.
module tb_transformation_sequencer;
   import transformation_pkg::*;

   localparam int FR  = 6;
   localparam int WC  = 3;
   localparam int FW  = 5;
   localparam int WW  = 5;
   localparam int VL  = 96;
   localparam int DPW = 16;
   localparam int CFW = $clog2(FR);
   localparam int CWW = $clog2(WC);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   transformation_sequencer_if #(
      .FEATURE_WIDTH(FW), .WEIGHT_WIDTH(WW), .VECTOR_LENGTH(VL), .DOT_PROD_WIDTH(DPW),
      .COUNTER_FEATURE_WIDTH(CFW), .COUNTER_WEIGHT_WIDTH(CWW)
   ) bus ();

   transformation_sequencer #(
      .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .FEATURE_WIDTH(FW), .WEIGHT_WIDTH(WW),
      .VECTOR_LENGTH(VL), .DOT_PROD_WIDTH(DPW),
      .COUNTER_FEATURE_WIDTH(CFW), .COUNTER_WEIGHT_WIDTH(CWW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   feature_vec_t fmem [8];
   weight_vec_t  wmem [4];
   weight_vec_t  wexp;

   // Synchronous-read memories: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.read_feature_enable) bus.feature_data <= fmem[bus.read_feature_address];
      if (bus.read_weight_enable)  bus.weight_data  <= wmem[bus.read_weight_address];
   end

   // Multiplier model: 3 cycles per row, product = row + 10*col two edges after INCR_FEATURE.
   logic        mult_auto = 1'b1;
   logic        auto_incr = 1'b0, auto_done = 1'b0;
   logic [15:0] auto_prod = '0;
   logic        man_incr = 1'b0, man_done = 1'b0;
   logic [15:0] man_prod = '0;
   int          cyc = 0, mrow = 0, mcol = 0;
   logic [1:0]  dv = '0;
   logic [15:0] dp0 = '0, dp1 = '0;

   always @(negedge clk) begin
      auto_incr = 1'b0;
      auto_done = 1'b0;
      if (!bus.busy) begin
         cyc = 0; mrow = 0; mcol = 0; dv = '0;
      end else begin
         if (dv[1]) begin auto_done = 1'b1; auto_prod = dp1; end
         dv[1] = dv[0];
         dp1   = dp0;
         dv[0] = 1'b0;
         if (bus.MULTI_EN) begin
            cyc++;
            if (cyc == 3) begin
               cyc = 0;
               auto_incr = 1'b1;
               dv[0] = 1'b1;
               dp0 = 16'(mrow + 10 * mcol);
               mrow++;
               if (mrow == FR) begin mrow = 0; mcol++; end
            end
         end else begin
            cyc = 0;
         end
      end
   end

   assign bus.INCR_FEATURE = mult_auto ? auto_incr : man_incr;
   assign bus.done         = mult_auto ? auto_done : man_done;
   assign bus.product      = mult_auto ? auto_prod : man_prod;

   // Event logs, written only here; tests index relative to a captured base.
   int                 wr_n = 0, fm_n = 0, td_n = 0;
   logic [CFW-1:0]     wr_row [256];
   logic [CWW-1:0]     wr_col [256];
   logic [DPW-1:0]     wr_dat [256];
   logic [FW-1:0]      fm_val [256];
   logic               fm_inc [256];
   logic [FW*VL-1:0]   fm_prev = '0;
   logic               incr_s;

   always @(posedge clk) begin
      incr_s = bus.INCR_FEATURE;
      #1;
      if (bus.result_write_enable) begin
         if (wr_n < 256) begin
            wr_row[wr_n] = bus.result_row_address;
            wr_col[wr_n] = bus.result_col_address;
            wr_dat[wr_n] = bus.result_data;
         end
         wr_n++;
      end
      if (bus.TRANS_DONE) td_n++;
      if (bus.FM_row !== fm_prev) begin
         if (fm_n < 256) begin
            fm_val[fm_n] = bus.FM_row[FW-1:0];
            fm_inc[fm_n] = incr_s;
         end
         fm_n++;
         fm_prev = bus.FM_row;
      end
   end

   function automatic logic [33:0] ctl_snapshot();
      return {bus.busy, bus.complete, bus.MULTI_EN, bus.TRANS_DONE, bus.read_feature_enable,
              bus.read_weight_enable, bus.result_write_enable, bus.result_overrun,
              bus.read_feature_address, bus.read_weight_address, bus.result_row_address,
              bus.result_col_address, bus.result_data};
   endfunction

   task automatic wait_complete(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.complete) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      reset_n = 1'b0;
      for (int r = 0; r < 8; r++)
         for (int e = 0; e < VL; e++) fmem[r][e*FW +: FW] = FW'(r + 1);
      for (int e = 0; e < VL; e++) wexp[e*WW +: WW] = WW'(1);
      for (int c = 0; c < 4; c++) wmem[c] = wexp;
      repeat (3) @(negedge clk);
      checks++;
      if (ctl_snapshot() !== 34'd0) begin
         failures++; $display("FAIL reset_ctl: got %h expected 0", ctl_snapshot());
      end
      checks++;
      if (bus.FM_row !== '0) begin
         failures++; $display("FAIL reset_fm_row: got %h expected 0", bus.FM_row[31:0]);
      end
      checks++;
      if (bus.WM_col !== '0) begin
         failures++; $display("FAIL reset_wm_col: got %h expected 0", bus.WM_col[31:0]);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_pass();
      bit ok;
      int wb = wr_n, fb = fm_n, tb0 = td_n;
      bus.start = 1'b1;
      wait_complete(2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL pass_timeout: complete=%0b expected 1", bus.complete); end
      checks++;
      if (wr_n - wb != FR * WC) begin
         failures++; $display("FAIL pass_write_count: got %0d expected %0d", wr_n - wb, FR * WC);
      end
      for (int i = 0; i < FR * WC; i++) begin
         checks++;
         if ({wr_row[wb+i], wr_col[wb+i], wr_dat[wb+i]} !==
             {CFW'(i % FR), CWW'(i / FR), 16'(i % FR + 10 * (i / FR))}) begin
            failures++;
            $display("FAIL pass_write_%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", i,
                     wr_row[wb+i], wr_col[wb+i], wr_dat[wb+i], i % FR, i / FR, i % FR + 10 * (i / FR));
         end
      end
      checks++;
      if (td_n - tb0 != 1) begin failures++; $display("FAIL pass_trans_done: got %0d pulses expected 1", td_n - tb0); end
      checks++;
      if ({bus.complete, bus.busy} !== 2'b10) begin
         failures++; $display("FAIL pass_end_status: complete,busy=%b expected 10", {bus.complete, bus.busy});
      end
      checks++;
      if (fm_n - fb != FR * WC) begin
         failures++; $display("FAIL fm_change_count: got %0d expected %0d", fm_n - fb, FR * WC);
      end
      for (int i = 0; i < FR * WC; i++) begin
         checks++;
         if ({fm_val[fb+i], fm_inc[fb+i]} !== {FW'(i % FR + 1), (i % FR) != 0}) begin
            failures++;
            $display("FAIL fm_change_%0d: got value=%0d after_incr=%0b expected value=%0d after_incr=%0b",
                     i, fm_val[fb+i], fm_inc[fb+i], i % FR + 1, (i % FR) != 0);
         end
      end
      checks++;
      if (bus.WM_col !== wexp) begin failures++; $display("FAIL wm_col: got %h expected %h", bus.WM_col[31:0], wexp[31:0]); end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.complete !== 1'b0) begin failures++; $display("FAIL complete_clear: got %b expected 0", bus.complete); end
   endtask

   task automatic test_overrun();
      bit ok;
      int wb = wr_n;
      mult_auto = 1'b0;
      man_done = 1'b1; man_prod = 16'h1234;
      @(negedge clk);
      man_done = 1'b0;
      checks++;
      if (bus.result_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", bus.result_overrun); end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.result_overrun, wr_n == wb} !== 2'b11) begin
         failures++; $display("FAIL overrun_hold: overrun=%b writes=%0d expected 1 and 0", bus.result_overrun, wr_n - wb);
      end
      bus.start = 1'b1;
      mult_auto = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.result_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b expected 0", bus.result_overrun); end
      wait_complete(2000, ok);
      checks++;
      if (!ok || (wr_n - wb != FR * WC)) begin
         failures++; $display("FAIL back_to_back: done=%0b writes=%0d expected 1 and %0d", ok, wr_n - wb, FR * WC);
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_pass();
      bit ok = 1'b0;
      int wb = wr_n;
      bus.start = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (wr_n - wb >= FR + 3) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL midpass_reach: writes=%0d expected %0d", wr_n - wb, FR + 3); end
      reset_n = 1'b0;
      bus.start = 1'b0;
      #1;
      checks++;
      if ({ctl_snapshot(), bus.FM_row == '0, bus.WM_col == '0} !== {34'd0, 2'b11}) begin
         failures++; $display("FAIL async_reset: ctl=%h fm0=%b wm0=%b expected 0,1,1",
                              ctl_snapshot(), bus.FM_row == '0, bus.WM_col == '0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      wb = wr_n;
      bus.start = 1'b1;
      wait_complete(2000, ok);
      checks++;
      if (!ok || (wr_n - wb != FR * WC)) begin
         failures++; $display("FAIL replay_count: done=%0b writes=%0d expected 1 and %0d", ok, wr_n - wb, FR * WC);
      end
      checks++;
      if ({wr_row[wb], wr_col[wb], wr_dat[wb], wr_row[wb+17], wr_col[wb+17], wr_dat[wb+17]} !==
          {CFW'(0), CWW'(0), 16'd0, CFW'(5), CWW'(2), 16'd25}) begin
         failures++; $display("FAIL replay_order: first (%0d,%0d)=%0d last (%0d,%0d)=%0d expected (0,0)=0 (5,2)=25",
                              wr_row[wb], wr_col[wb], wr_dat[wb], wr_row[wb+17], wr_col[wb+17], wr_dat[wb+17]);
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_incr_with_done();
      int wb = wr_n, tdb = td_n;
      bit found;
      int early;
      mult_auto = 1'b0;
      bus.start = 1'b1;
      for (int col = 0; col < WC; col++) begin
         found = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (bus.MULTI_EN) begin found = 1'b1; break; end
            @(negedge clk);
         end
         checks++;
         if (!found) begin
            failures++; $display("FAIL manual_run_col%0d: MULTI_EN=%b expected 1", col, bus.MULTI_EN);
            return;
         end
         for (int r = 0; r < FR; r++) begin
            repeat (2) @(negedge clk);
            man_incr = 1'b1;
            if (r > 0) begin man_done = 1'b1; man_prod = 16'((r - 1) + 10 * col); end
            @(negedge clk);
            man_incr = 1'b0; man_done = 1'b0;
         end
         early = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.read_weight_enable || bus.TRANS_DONE || !bus.busy) early++;
         end
         checks++;
         if ((early != 0) || (wr_n - wb != col * FR + FR - 1)) begin
            failures++; $display("FAIL drain_hold_col%0d: early_exit=%0d writes=%0d expected 0 and %0d",
                                 col, early, wr_n - wb, col * FR + FR - 1);
         end
         man_done = 1'b1; man_prod = 16'(5 + 10 * col);
         @(negedge clk);
         man_done = 1'b0;
         checks++;
         if ((wr_n - wb != col * FR + FR) ||
             ({wr_row[wr_n-1], wr_col[wr_n-1], wr_dat[wr_n-1]} !== {CFW'(5), CWW'(col), 16'(5 + 10 * col)})) begin
            failures++; $display("FAIL final_done_col%0d: writes=%0d last (%0d,%0d)=%0d expected %0d (5,%0d)=%0d",
                                 col, wr_n - wb, wr_row[wr_n-1], wr_col[wr_n-1], wr_dat[wr_n-1],
                                 col * FR + FR, col, 5 + 10 * col);
         end
         @(negedge clk);
         checks++;
         if (col < WC - 1) begin
            if (bus.read_weight_enable !== 1'b1) begin
               failures++; $display("FAIL drain_exit_col%0d: read_weight_enable=%b expected 1", col, bus.read_weight_enable);
            end
         end else if (bus.TRANS_DONE !== 1'b1) begin
            failures++; $display("FAIL drain_exit_finish: TRANS_DONE=%b expected 1", bus.TRANS_DONE);
         end
      end
      checks++;
      if (td_n - tdb != 1) begin failures++; $display("FAIL manual_trans_done: got %0d pulses expected 1", td_n - tdb); end
   endtask

   task automatic test_start_held();
      int bad = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (!bus.complete || bus.busy || bus.read_weight_enable) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL complete_hold: bad_cycles=%0d expected 0", bad); end
      bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.complete, bus.busy} !== 2'b00) begin
         failures++; $display("FAIL complete_release: complete,busy=%b expected 00", {bus.complete, bus.busy});
      end
      bus.start = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.read_weight_enable} !== 2'b11) begin
         failures++; $display("FAIL restart: busy,read_weight_enable=%b expected 11", {bus.busy, bus.read_weight_enable});
      end
      bus.start = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      mult_auto = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_overrun();
      test_reset_mid_pass();
      test_incr_with_done();
      test_start_held();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
